// File: rtl/dmem_access_ctrl.sv
// Data-side memory controller for the MIPS MEM stage: generates the pipeline advance enable,
// sequences direct-mapped cache block refills on read misses and write-through stores.
module dmem_access_ctrl #(
   parameter int BLOCK_WORDS = 4,
   parameter int WIDX_W      = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic              cache_hit,
   input  logic              mem_ack,
   output logic              data_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic              refill_we,
   output logic [WIDX_W-1:0] refill_word,
   output logic              refill_tag_we,
   output logic              busy,
   output logic [CNT_W-1:0]  miss_count
);

   typedef enum logic [1:0] {IDLE, REFILL, REPLAY, WRITE} state_t;

   localparam logic [31:0]       BLOCK_MASK = 32'(BLOCK_WORDS * 4 - 1);
   localparam logic [WIDX_W-1:0] LAST_WORD  = WIDX_W'(BLOCK_WORDS - 1);

   state_t            state, next_state;
   logic [WIDX_W-1:0] word_cnt;
   logic [31:0]       addr_q;
   logic              load_write, load_miss, cnt_clr;

   // One address register serves both transaction kinds: the word address for a store,
   // the block base for a refill (low bits zero, so the word offset can be OR-ed in).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         addr_q     <= '0;
         miss_count <= '0;
      end else begin
         state <= next_state;
         if (load_write)
            addr_q <= {addr[31:2], 2'b00};
         if (load_miss) begin
            addr_q <= addr & ~BLOCK_MASK;
            if (miss_count != {CNT_W{1'b1}})
               miss_count <= miss_count + CNT_W'(1);
         end
         if (load_miss || cnt_clr)
            word_cnt <= '0;
         else if (refill_we)
            word_cnt <= word_cnt + WIDX_W'(1);
      end
   end

   always_comb begin
      next_state    = state;
      data_hit      = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      refill_we     = 1'b0;
      refill_tag_we = 1'b0;
      load_write    = 1'b0;
      load_miss     = 1'b0;
      cnt_clr       = 1'b0;
      unique case (state)
         IDLE: begin
            data_hit = !mem_write && (!mem_read || cache_hit);
            if (mem_write) begin
               load_write = 1'b1;
               next_state = WRITE;
            end else if (mem_read && !cache_hit) begin
               load_miss  = 1'b1;
               next_state = REFILL;
            end
         end
         REFILL: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               refill_we = 1'b1;
               if (word_cnt == LAST_WORD) begin
                  refill_tag_we = 1'b1;
                  next_state    = REPLAY;
               end
            end
         end
         // A conflicting cache update can evict the block before replay; refetch it
         // without counting another miss.
         REPLAY: begin
            data_hit = cache_hit;
            if (cache_hit) begin
               next_state = IDLE;
            end else begin
               cnt_clr    = 1'b1;
               next_state = REFILL;
            end
         end
         WRITE: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            data_hit = mem_ack;
            if (mem_ack)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign mem_addr    = (state == REFILL) ? (addr_q | {{(30-WIDX_W){1'b0}}, word_cnt, 2'b00}) : addr_q;
   assign refill_word = word_cnt;
   assign busy        = (state != IDLE);

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-side memory controller for the MIPS pipeline MEM stage.
- Produces the `data_hit` advance enable consumed by the MEM/WB pipeline register and the upstream stage registers.
- Sequences direct-mapped data-cache block refills on read misses and write-through stores to main memory over a req/ack handshake.
- Stalls the pipeline (`data_hit`=0) for the duration of any memory transaction.

Parameters:
- BLOCK_WORDS, 4, 32-bit words per cache block; power of two, 2..16.
- WIDX_W, 2, log2(BLOCK_WORDS); width of word index.
- CNT_W, 16, width of the saturating miss counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  MEM-stage load.
- mem_write  in  1  MEM-stage store.
- addr  in  32  MEM-stage byte address (ALU result).
- cache_hit  in  1  cache tag match and valid for addr, combinational from cache.
- mem_ack  in  1  main memory accepts/completes the current word.
- data_hit  out  1  pipeline advance enable; 1 = MEM stage completes this cycle.
- mem_req  out  1  main-memory request.
- mem_we  out  1  1 = write request, 0 = read request; valid while mem_req=1.
- mem_addr  out  32  word-aligned main-memory address.
- refill_we  out  1  write mem_rdata into cache data array at refill_word.
- refill_word  out  WIDX_W  word index within the block being refilled.
- refill_tag_we  out  1  update cache tag and set valid for the refill block.
- busy  out  1  FSM not in IDLE.
- miss_count  out  CNT_W  number of read misses since reset; saturates at all-ones.

Behaviour:
- States: IDLE, REFILL, REPLAY, WRITE. Encoding is free. All registered state updates on rising clk.
- Reset (async, rst_n=0):
  - state=IDLE, word counter=0, latched addresses=0, miss_count=0.
  - mem_req, mem_we, refill_we, refill_tag_we, busy = 0.
  - data_hit follows the IDLE rule below.
  - Reset mid-transaction abandons it immediately; a partial refill leaves the tag unwritten, so the block stays invalid.
- `data_hit` is combinational:
  - IDLE: data_hit = !mem_write & (!mem_read | cache_hit). No access or a read hit costs 0 stall cycles.
  - REPLAY: data_hit = cache_hit.
  - WRITE: data_hit = mem_ack.
  - REFILL: data_hit = 0.
- IDLE transitions:
  - mem_write=1 (regardless of mem_read): latch `{addr[31:2],2'b00}`, go to WRITE.
  - Else mem_read=1 & cache_hit=0: latch block base `{addr[31:2+WIDX_W], zeros}`, clear word counter, increment miss_count (saturating), go to REFILL.
  - Otherwise stay in IDLE.
- REFILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr = base + 4*counter, refill_word=counter. Outputs hold stable until mem_ack.
  - Each cycle with mem_ack=1: refill_we=1 and counter++.
  - On the ack where counter==BLOCK_WORDS-1: refill_tag_we=1 in that same cycle, counter wraps to 0, next state REPLAY.
  - Back-to-back acks are legal (one word per cycle minimum latency).
- REPLAY:
  - mem_req=0; the cache array now holds the block.
  - cache_hit=1: data_hit=1, next state IDLE.
  - cache_hit=0 (conflicting update): re-enter REFILL with the counter cleared; miss_count is not incremented again.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_addr = latched word address.
  - On mem_ack: data_hit=1 in that cycle, next state IDLE. A store hit updates the cache using data_hit&mem_write&cache_hit, which is the cache's responsibility.
- Input qualification:
  - mem_ack while mem_req=0 is ignored.
  - addr, mem_read and mem_write are sampled only in IDLE. They are held stable by the stalled pipeline thereafter.
- busy = (state != IDLE).
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss: BLOCK_WORDS ack cycles plus 1 REPLAY cycle.
  - Store: stalls until mem_ack, with data_hit asserted on the ack cycle.

Test Plan:
- Reset, then mem_read=1, cache_hit=1, addr=0x100 → data_hit=1 same cycle, mem_req=0, busy=0.
- Read miss addr=0x1234, BLOCK_WORDS=4, mem_ack tied 1:
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C with refill_word 0..3 and refill_we on each.
  - refill_tag_we only on the 4th.
  - REPLAY with cache_hit=1 → data_hit=1; miss_count=1.
- Read miss with mem_ack asserted every 3rd cycle → mem_addr/refill_word held between acks; data_hit=0 throughout refill; total stall = 12 cycles + 1 REPLAY.
- Store addr=0x2006, mem_ack delayed 5 cycles → mem_req=1, mem_we=1, mem_addr=0x2004 for 5 cycles; data_hit=1 only on the ack cycle; then IDLE.
- rst_n pulsed low after 2 refill acks → immediate IDLE, mem_req=0, miss_count=0, no refill_tag_we ever asserted for that block.
- mem_read=1 and mem_write=1 together, cache_hit=1 → treated as store (WRITE state, mem_we=1); REPLAY with cache_hit=0 → re-refill without a second miss_count increment.
